// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: base^exponent mod p by left-to-right square-and-multiply over an external modular multiplier.
// Define MODEXP_SKIP_LEADING_ZEROS_EN to start at the exponent's highest set bit. dbg_state: IDLE=0 .. FIN=6.
module mod_exp_ctrl #(
  parameter int p      = 37,
  parameter int width  = 128,
  parameter int ewidth = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [width-1:0]  base,
  input  logic [ewidth-1:0] exponent,
  output logic              busy,
  output logic              done,
  output logic [width-1:0]  result,
  output logic              mm_reset,
  output logic              mm_enable,
  output logic [width-1:0]  mm_a,
  output logic [width-1:0]  mm_b,
  input  logic [width-1:0]  mm_r,
  input  logic              mm_done,
  output logic [2:0]        dbg_state
);

  // Multiplier handshake: one mm_reset cycle (ISSUE) with operands already on mm_a/mm_b, then
  // mm_enable stays high until mm_done is sampled high; that edge captures mm_r and drops mm_enable.
  // mm_done is a level and is looked at only in WAIT states, so a stale high during ISSUE is harmless.

  localparam int IW = (ewidth > 1) ? $clog2(ewidth) : 1;
  localparam logic [width-1:0] ONE     = width'(1 % p);
  localparam logic [IW-1:0]    IDX_TOP = IW'(ewidth - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SQ_ISSUE = 3'd1,
    SQ_WAIT  = 3'd2,
    MU_ISSUE = 3'd3,
    MU_WAIT  = 3'd4,
    NEXT     = 3'd5,
    FIN      = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [width-1:0]  acc;
  logic [width-1:0]  b_q;
  logic [ewidth-1:0] e_q;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     start_idx;
  logic              exp_zero;
  logic              accept;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  always_comb begin
    start_idx = '0;
    for (int i = 0; i < ewidth; i++) begin
      if (exponent[i]) start_idx = IW'(i);
    end
  end
  assign exp_zero = (exponent == '0);
`else
  assign start_idx = IDX_TOP;
  assign exp_zero  = 1'b0;
`endif

  // A start landing on the done cycle is dropped even though the FSM is already back in IDLE.
  assign accept    = (state == IDLE) && start && !done;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = exp_zero ? NEXT : SQ_ISSUE;
      SQ_ISSUE: state_nxt = SQ_WAIT;
      SQ_WAIT:  if (mm_done) state_nxt = e_q[idx] ? MU_ISSUE : NEXT;
      MU_ISSUE: state_nxt = MU_WAIT;
      MU_WAIT:  if (mm_done) state_nxt = NEXT;
      NEXT:     state_nxt = (idx == '0) ? FIN : SQ_ISSUE;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= ONE;
      b_q       <= '0;
      e_q       <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      mm_reset  <= 1'b1;
      mm_enable <= 1'b0;
      mm_a      <= '0;
      mm_b      <= '0;
    end else begin
      state     <= state_nxt;
      done      <= (state == FIN);
      mm_reset  <= (state_nxt == SQ_ISSUE) || (state_nxt == MU_ISSUE);
      mm_enable <= (state_nxt == SQ_WAIT) || (state_nxt == MU_WAIT);

      // Operands load on the edge into an ISSUE state, so they are present while the
      // multiplier is held in reset and cannot move once mm_enable is up.
      case (state)
        IDLE: begin
          if (accept) begin
            b_q  <= base;
            e_q  <= exponent;
            acc  <= ONE;
            idx  <= start_idx;
            busy <= 1'b1;
            if (!exp_zero) begin
              mm_a <= ONE;
              mm_b <= ONE;
            end
          end
        end
        SQ_WAIT: begin
          if (mm_done) begin
            acc <= mm_r;
            if (e_q[idx]) begin
              mm_a <= mm_r;
              mm_b <= b_q;
            end
          end
        end
        MU_WAIT: begin
          if (mm_done) acc <= mm_r;
        end
        NEXT: begin
          if (idx != '0) begin
            idx  <= idx - 1'b1;
            mm_a <= acc;
            mm_b <= acc;
          end
        end
        FIN: result <= acc;
        default: ;
      endcase

      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural multiplier with fixed or random latency, plain-arithmetic modexp model.
module tb_mod_exp_ctrl;
  localparam int P  = 37;
  localparam int W  = 8;
  localparam int EW = 8;

  // clock / reset
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  base = '0;
  logic [EW-1:0] exponent = '0;
  logic          busy, done, mm_reset, mm_enable, mm_done;
  logic [W-1:0]  result, mm_a, mm_b, mm_r;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mod_exp_ctrl #(.p(P), .width(W), .ewidth(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
    .busy(busy), .done(done), .result(result),
    .mm_reset(mm_reset), .mm_enable(mm_enable), .mm_a(mm_a), .mm_b(mm_b),
    .mm_r(mm_r), .mm_done(mm_done), .dbg_state(dbg_state)
  );

  // behavioural multiplier: done level L enable-cycles after the first enable cycle
  bit           rand_lat = 1'b0;
  bit           inject = 1'b0;
  logic         mult_done_q = 1'b0;
  logic         glitch_q = 1'b0;
  logic [W-1:0] mult_r_q = '0;
  int           mult_cnt = 0;
  int           mult_lat = 4;

  always @(posedge clk) begin
    if (mm_reset) begin
      mult_cnt    <= 0;
      mult_done_q <= 1'b0;
      mult_lat    <= rand_lat ? int'($urandom_range(1, 20)) : 4;
    end else if (mm_enable && !mult_done_q) begin
      if (mult_cnt == mult_lat - 1) begin
        mult_done_q <= 1'b1;
        mult_r_q    <= W'((int'(mm_a) * int'(mm_b)) % P);
      end else begin
        mult_cnt <= mult_cnt + 1;
      end
    end
  end

  always @(negedge clk) glitch_q <= inject && mm_reset && ($urandom_range(0, 1) == 1);
  assign mm_done = mult_done_q | glitch_q;
  assign mm_r    = mult_r_q;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // monitor
  logic         prev_en = 1'b0, prev_rst = 1'b1;
  logic [W-1:0] prev_a = '0, prev_b = '0;
  int en_rises = 0, rst_rises = 0, unstable = 0, done_cnt = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (mm_enable && !prev_en) en_rises++;
    if (mm_reset && !prev_rst) rst_rises++;
    if (mm_enable && prev_en && (mm_a != prev_a || mm_b != prev_b)) unstable++;
    prev_en  = mm_enable;
    prev_rst = mm_reset;
    prev_a   = mm_a;
    prev_b   = mm_b;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_q.size() > 0) check("result", 32'(result), 32'(exp_q.pop_front()));
      else check("unexpected_done", 32'(done), 32'd0);
    end
  end

  // reference model
  function automatic int ref_modexp(input int b, input int e);
    int r = 1 % P;
    int x = b % P;
    for (int i = 0; i < EW; i++) begin
      if (((e >> i) & 1) == 1) r = (r * x) % P;
      x = (x * x) % P;
    end
    return r;
  endfunction

  function automatic int popcnt(input int e);
    int n = 0;
    for (int i = 0; i < EW; i++) if (((e >> i) & 1) == 1) n++;
    return n;
  endfunction

  function automatic int bits_processed(input int e);
    int n = 0;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    for (int i = 0; i < EW; i++) if (((e >> i) & 1) == 1) n = i + 1;
`else
    n = EW;
`endif
    return n;
  endfunction

  // driver
  task automatic run_op(input int b, input int e, input bit chk_lat);
    int s, m, lat_exp, t0, waited;
    s = bits_processed(e);
    m = popcnt(e);
    lat_exp = 1 + (s + m) * (4 + 2) + s + 1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    if (e == 0) lat_exp = 3;
`endif
    @(posedge clk);
    en_rises = 0; rst_rises = 0; unstable = 0; done_cnt = 0;
    @(negedge clk);
    base = W'(b); exponent = EW'(e); start = 1'b1; t0 = cyc;
    exp_q.push_back(W'(ref_modexp(b, e)));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    waited = 0;
    while (done_cnt == 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    if (chk_lat) check("latency", 32'(done_cyc - t0), 32'(lat_exp));
    check("mm_ops", 32'(en_rises), 32'(s + m));
    check("mm_reset_pulses", 32'(rst_rises), 32'(s + m));
    check("operand_stable", 32'(unstable), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int w, tgt;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_mm_reset", 32'(mm_reset), 32'd1);
    check("rst_mm_enable", 32'(mm_enable), 32'd0);
    check("rst_mm_a", 32'(mm_a), 32'd0);
    check("rst_mm_b", 32'(mm_b), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // directed cases with fixed L=4
    run_op(5, 3, 1'b1);
    run_op(2, 36, 1'b1);
    run_op(5, 35, 1'b1);
    run_op(9, 0, 1'b1);
    run_op(0, 255, 1'b1);
    run_op(36, 128, 1'b1);

    // random latency and stale/injected mm_done in ISSUE cycles
    rand_lat = 1'b1;
    inject = 1'b1;
    run_op(5, 3, 1'b0);
    for (int i = 0; i < 15; i++) run_op(int'($urandom_range(0, P - 1)), int'($urandom_range(0, 255)), 1'b0);
    rand_lat = 1'b0;
    inject = 1'b0;

    // reset while waiting on the first multiply
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    tgt = 2;
`else
    tgt = 8;
`endif
    @(posedge clk);
    en_rises = 0; done_cnt = 0;
    @(negedge clk);
    base = 8'd5; exponent = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (en_rises < tgt && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("reached_mu_wait", 32'(en_rises), 32'(tgt));
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mm_enable", 32'(mm_enable), 32'd0);
    check("abort_mm_reset", 32'(mm_reset), 32'd1);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(36, 1, 1'b1);

    // second start while busy, and a start coincident with done
    @(posedge clk);
    done_cnt = 0; en_rises = 0;
    @(negedge clk);
    base = 8'd2; exponent = 8'd36; start = 1'b1;
    exp_q.push_back(W'(ref_modexp(2, 36)));
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    base = 8'd3; exponent = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!done && w < 3000) begin
      @(negedge clk);
      w++;
    end
    base = 8'd3; exponent = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_start_done_pulses", 32'(done_cnt), 32'd1);
    check("coincident_start_busy", 32'(busy), 32'd0);
    check("busy_start_mm_ops", 32'(en_rises), 32'(bits_processed(36) + popcnt(36)));
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Modular exponentiation controller computing `result = base^exponent mod p` by left-to-right square-and-multiply. The block is the initiator of the modular multiplier's enable/done handshake. It owns one external modular-multiplier instance through the `mm_*` port group, sequencing operands and reset pulses into it and capturing its remainder output. It is intended for the scalar/field pipeline wherever powers are needed, e.g. Fermat inversion with exponent p-2.

## Interface
- `p`, default 37: field modulus; must match the attached multiplier.
- `width`, default 128: operand and result width.
- `ewidth`, default 128: exponent width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `base`  in  width  base, must be < p; captured on accepted start.
- `exponent`  in  ewidth  exponent; captured on accepted start.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  width  final value; held until the next accepted start.
- `mm_reset`  out  1  reset pulse to the multiplier.
- `mm_enable`  out  1  multiplier enable, held high until `mm_done`.
- `mm_a`, `mm_b`  out  width  multiplier operands.
- `mm_r`  in  width  multiplier remainder.
- `mm_done`  in  1  multiplier completion level.

## Operation
- Registers:
  - `acc` (width bits), initialised to `1 % p`.
  - `b_q` (width bits).
  - `e_q` (ewidth bits).
  - Bit index `idx`, ceil(log2(ewidth)) bits.
- States: IDLE, SQ_ISSUE, SQ_WAIT, MU_ISSUE, MU_WAIT, NEXT, FIN.
- IDLE:
  - On `start`, capture `base` and `exponent`, set `acc = 1 % p` and `idx = ewidth-1`, then go to SQ_ISSUE.
  - `start` is ignored in every other state.
- SQ_ISSUE: drive `mm_reset=1`, `mm_enable=0`, `mm_a=mm_b=acc` for one cycle, then go to SQ_WAIT.
- SQ_WAIT:
  - Drive `mm_enable=1` with the operands held stable.
  - On the first cycle `mm_done=1`, load `acc <= mm_r` and drop `mm_enable`.
  - Then go to MU_ISSUE if `e_q[idx]=1`, else go to NEXT.
- MU_ISSUE: as SQ_ISSUE, but with `mm_a=acc` and `mm_b=b_q`; then go to MU_WAIT.
- MU_WAIT: as SQ_WAIT; on `mm_done`, load `acc <= mm_r` and go to NEXT.
- NEXT: if `idx==0`, go to FIN; else decrement `idx` and go to SQ_ISSUE.
- FIN: `result <= acc`, pulse `done`, return to IDLE.
- Operands:
  - `mm_a` and `mm_b` are registered.
  - They change only in ISSUE states.
  - They never change while `mm_enable=1`.
- `mm_done` is ignored outside the WAIT states. A stale high `mm_done` in an ISSUE state must not advance the FSM.
- Exponent 0 yields `1 % p`.
- No range check is performed on `base`.

## Timing
- Reset values:
  - `busy=0`, `done=0`, `result=0`.
  - `mm_reset=1`, `mm_enable=0`, `mm_a=0`, `mm_b=0`.
  - State is IDLE.
- `reset` asserted mid-operation aborts within one cycle: `mm_enable=0`, `mm_reset=1`, and no `done` pulse is issued.
- Multiplier latency L is the number of cycles from the first `mm_enable=1` cycle to `mm_done` sampled high. Each multiplier operation then costs L+2 cycles: ISSUE, L WAIT cycles, and the capture edge.
- Total latency from start to done = 1 + S·(L+2) + M·(L+2) + N + 1.
  - S = squarings.
  - M = number of 1 bits processed.
  - N = bits processed (one NEXT cycle each).
- `done` and `busy` fall in the same cycle; IDLE accepts a new start on the following cycle.
- A start pulse coincident with `done` is ignored.

## Configuration
- `MODEXP_SKIP_LEADING_ZEROS_EN`:
  - Defined: on an accepted start, `idx` is loaded with the position of the highest set bit of `exponent`, using a priority encoder on the capture cycle. The squarings of 1 for leading zero bits are not issued.
  - If `exponent==0`, go directly to FIN with result `1 % p`: zero multiplier operations and done three cycles after start.
  - Undefined: all ewidth bits are processed, so S = ewidth.
- Results are identical with and without the macro; only cycle count and multiplier operation count differ.

## Test plan
All scenarios use `p=37`, `width=8`, `ewidth=8`, and a behavioural multiplier with fixed L=4.

- Base exponent: `base=5`, `exponent=3`.
  - Required: `result=14` with one `done` pulse.
  - With the macro: exactly 4 `mm_enable` rising edges.
  - Without the macro: 10 rising edges.
- Fermat case: `base=2`, `exponent=36`.
  - Required: `result=1`.
  - Separately, `base=5`, `exponent=35` (p-2) gives `result=15`, the inverse of 5, since 5·15=75≡1.
- Exponent zero: `base=9`, `exponent=0`.
  - Required: `result=1`.
  - With the macro: no `mm_enable` activity and `done` 3 cycles after start.
- Handshake: delay `mm_done` by a random 1–20 cycles per operation, and inject `mm_done=1` during ISSUE cycles.
  - Required: operands stable while `mm_enable=1`, exactly one `mm_reset` pulse per operation, unchanged result.
- Reset mid-operation: assert `reset` during MU_WAIT.
  - Required: next cycle `busy=0`, `mm_enable=0`, no `done`.
  - A fresh start (`base=36`, `exponent=1`) then gives `result=36`.
- Start during busy: a second start with `base=3` is ignored and the first result is delivered unchanged.
